anfsqrt_isqrt_pipe: RTL and testbench

//  Parametrised iterative integer square root with valid/ready handshakes.

---
 rtl/anfsqrt_pkg.sv | 31 +++
 rtl/anfsqrt_isqrt_step.sv | 37 +++
 rtl/anfsqrt_isqrt_pipe.sv | 130 +++++++++++++
 tb/tb_anfsqrt_isqrt_pipe.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/anfsqrt_pkg.sv
// anfsqrt_pkg: shared types and sizing helpers for the iterative integer square root.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state_e (IDLE/BUSY/DONE, 2 bits); half_w, iter_cnt and idx_w derive N, L and the idx width from WIDTH/UNROLL.
package anfsqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int ANFSQRT_DEF_WIDTH  = 16;
  localparam int ANFSQRT_DEF_UNROLL = 1;

  // Root width N.
  function automatic int half_w(input int width);
    return width / 2;
  endfunction

  // Number of BUSY cycles L = N / UNROLL.
  function automatic int iter_cnt(input int width, input int unroll);
    return (width / 2) / unroll;
  endfunction

  // Bits needed to hold a root bit index 0..N-1 (at least 1).
  function automatic int idx_w(input int width);
    return ((width / 2) > 1) ? $clog2(width / 2) : 1;
  endfunction

endpackage

// File: rtl/anfsqrt_isqrt_step.sv
// anfsqrt_isqrt_step: one restoring square-root recurrence step, resolving root bit i.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
// Ports: eps_i/eps_o remaining radicand (X - root^2), root_i/root_o partial root, i_i bit index being resolved.
module anfsqrt_isqrt_step
  import anfsqrt_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]         eps_i,
  input  logic [WIDTH/2-1:0]       root_i,
  input  logic [idx_w(WIDTH)-1:0]  i_i,
  output logic [WIDTH-1:0]         eps_o,
  output logic [WIDTH/2-1:0]       root_o
);

  localparam int N  = half_w(WIDTH);
  // One spare bit so the trial value never wraps, whatever i is.
  localparam int TW = WIDTH + 1;

  logic [TW-1:0] eps_x;
  logic [TW-1:0] trial;

  always_comb begin
    eps_x  = {1'b0, eps_i};
    // (root + 2^i)^2 - root^2 = (root << (i+1)) + 2^(2i); the <<1 is done
    // separately so i+1 cannot overflow the index width.
    trial  = ((TW'(root_i) << 1) << i_i) + (TW'(1) << {i_i, 1'b0});
    eps_o  = eps_i;
    root_o = root_i;
    if (trial <= eps_x) begin
      eps_o  = WIDTH'(eps_x - trial);
      root_o = root_i | (N'(1) << i_i);
    end
  end

endmodule

// File: rtl/anfsqrt_isqrt_pipe.sv
// anfsqrt_isqrt_pipe: floor(sqrt(X)) of a WIDTH-bit unsigned radicand, UNROLL root bits per clock.
// Latency: out_valid rises N/UNROLL edges after the accepting edge; one query in flight.
// Backpressure: in_ready low while BUSY/DONE; result held until out_ready (throughput 1 per L+2 cycles).
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_data query; out_valid/out_ready/out_root result;
//        out_rem = X - root^2, present only when the ANFSQRT_REM_EN macro is defined.
module anfsqrt_isqrt_pipe
  import anfsqrt_pkg::*;
#(
  parameter int WIDTH  = ANFSQRT_DEF_WIDTH,
  parameter int UNROLL = ANFSQRT_DEF_UNROLL
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef ANFSQRT_REM_EN
  output logic [WIDTH/2-1:0]    out_root,
  output logic [WIDTH/2:0]      out_rem
`else
  output logic [WIDTH/2-1:0]    out_root
`endif
);

  localparam int N    = half_w(WIDTH);
  localparam int IDXW = idx_w(WIDTH);

  if ((WIDTH % 2) != 0 || WIDTH < 4 || UNROLL < 1 || (N % UNROLL) != 0) begin : g_bad_param
    $error("anfsqrt_isqrt_pipe: WIDTH must be even and >= 4, UNROLL must divide WIDTH/2");
  end

  state_e            state_q;
  logic [IDXW-1:0]   idx_q;
  logic [WIDTH-1:0]  eps_q;
  logic [N-1:0]      root_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [N-1:0]      out_root_q;
`ifdef ANFSQRT_REM_EN
  logic [N:0]        out_rem_q;
`endif

  // Step chain: stage k resolves root bit idx_q-k. idx_q starts at N-1 and
  // drops by UNROLL, and UNROLL divides N, so idx_q-k never goes negative.
  logic [WIDTH-1:0]  eps_c  [UNROLL+1];
  logic [N-1:0]      root_c [UNROLL+1];
  logic [WIDTH-1:0]  eps_d;
  logic [N-1:0]      root_d;

  assign eps_c[0]  = eps_q;
  assign root_c[0] = root_q;

  for (genvar k = 0; k < UNROLL; k++) begin : g_step
    anfsqrt_isqrt_step #(
      .WIDTH (WIDTH)
    ) u_step (
      .eps_i  (eps_c[k]),
      .root_i (root_c[k]),
      .i_i    (idx_q - IDXW'(k)),
      .eps_o  (eps_c[k+1]),
      .root_o (root_c[k+1])
    );
  end

  assign eps_d  = eps_c[UNROLL];
  assign root_d = root_c[UNROLL];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      eps_q       <= '0;
      root_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_root_q  <= '0;
`ifdef ANFSQRT_REM_EN
      out_rem_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            eps_q      <= in_data;
            root_q     <= '0;
            idx_q      <= IDXW'(N - 1);
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          eps_q  <= eps_d;
          root_q <= root_d;
          // Lowest stage of this group is bit 0: the root is complete.
          if (idx_q == IDXW'(UNROLL - 1)) begin
            out_root_q  <= root_d;
`ifdef ANFSQRT_REM_EN
            // Remainder is at most 2*root, so N+1 bits hold it exactly.
            out_rem_q   <= eps_d[N:0];
`endif
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q - IDXW'(UNROLL);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_root  = out_root_q;
`ifdef ANFSQRT_REM_EN
  assign out_rem   = out_rem_q;
`endif

endmodule

// File: tb/tb_anfsqrt_isqrt_pipe.sv
// tb_anfsqrt_isqrt_pipe: three WIDTH=16 instances (UNROLL 1, 2, 8) against a plain-arithmetic sqrt model.
// Latency: checks out_valid arrives exactly N/UNROLL edges after accept.
// Backpressure: drives out_ready low to hold results and in_valid while not ready.
module tb_anfsqrt_isqrt_pipe;

  localparam int W = 16;
  localparam int N = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            iv   [3];
  logic            ir   [3];
  logic [W-1:0]    id   [3];
  logic            ov   [3];
  logic            ordy [3];
  logic [N-1:0]    oroot[3];
`ifdef ANFSQRT_REM_EN
  logic [N:0]      orem [3];
`endif

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  // Scoreboard: one query in flight per instance.
  int          acc_n [3] = '{0, 0, 0};
  int          done_n[3] = '{0, 0, 0};
  int          acc   [3];
  int unsigned px    [3];
  logic        ov_prev[3] = '{1'b0, 1'b0, 1'b0};
  logic        hs_prev[3] = '{1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef ANFSQRT_REM_EN
  anfsqrt_isqrt_pipe #(.WIDTH(W), .UNROLL(1)) u_un1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_root(oroot[0]), .out_rem(orem[0]));
  anfsqrt_isqrt_pipe #(.WIDTH(W), .UNROLL(2)) u_un2 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_root(oroot[1]), .out_rem(orem[1]));
  anfsqrt_isqrt_pipe #(.WIDTH(W), .UNROLL(8)) u_un8 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_root(oroot[2]), .out_rem(orem[2]));
`else
  anfsqrt_isqrt_pipe #(.WIDTH(W), .UNROLL(1)) u_un1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_root(oroot[0]));
  anfsqrt_isqrt_pipe #(.WIDTH(W), .UNROLL(2)) u_un2 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_root(oroot[1]));
  anfsqrt_isqrt_pipe #(.WIDTH(W), .UNROLL(8)) u_un8 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_root(oroot[2]));
`endif

  function automatic int lat(input int k);
    return (k == 0) ? 8 : (k == 1) ? 4 : 1;
  endfunction

  // Reference: largest r with r*r <= x, by direct search.
  function automatic void isqrt_ref(input int unsigned x, output int unsigned r, output int unsigned m);
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    m = x - r * r;
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Compare process: every negedge, each instance's outputs against the model.
  always @(negedge clk) begin
    int unsigned r, m;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        done_n[k]  = acc_n[k];
        ov_prev[k] = 1'b0;
        hs_prev[k] = 1'b0;
      end else begin
        if (hs_prev[k]) begin
          chk("out_valid_after_hs", ov[k], 0);
          chk("in_ready_after_hs", ir[k], 1);
        end
        if (ov[k]) begin
          if (acc_n[k] == done_n[k]) begin
            chk("spurious_out_valid", ov[k], 0);
          end else begin
            isqrt_ref(px[k], r, m);
            chk("root_vs_model", oroot[k], r);
            chk("in_ready_while_done", ir[k], 0);
`ifdef ANFSQRT_REM_EN
            chk("rem_vs_model", orem[k], m);
            chk("root2_plus_rem", int'(oroot[k]) * int'(oroot[k]) + int'(orem[k]), px[k]);
            chk("rem_le_2root", int'(orem[k]) <= 2 * int'(oroot[k]), 1);
`endif
            if (!ov_prev[k]) chk("latency", cyc - acc[k], lat(k));
            if (ordy[k]) done_n[k] = done_n[k] + 1;
          end
        end
        ov_prev[k] = ov[k];
        hs_prev[k] = ov[k] && ordy[k];
      end
    end
  end

  // All tasks run in the phase #1 after a rising edge.
  task automatic wait_ready(input int k);
    for (int t = 0; t < 100 && !ir[k]; t++) begin
      @(posedge clk); #1;
    end
    chk("in_ready_timeout", ir[k], 1);
  endtask

  task automatic send(input int k, input int unsigned x);
    wait_ready(k);
    iv[k] = 1'b1;
    id[k] = x[W-1:0];
    @(posedge clk); #1;
    acc[k] = cyc;
    px[k]  = x;
    acc_n[k] = acc_n[k] + 1;
    iv[k] = 1'b0;
    id[k] = ~x[W-1:0];   // must be ignored once accepted
  endtask

  task automatic wait_done(input int k);
    for (int t = 0; t < 100 && acc_n[k] != done_n[k]; t++) begin
      @(posedge clk); #1;
    end
    chk("result_timeout", acc_n[k] - done_n[k], 0);
  endtask

  task automatic send_lit(input int k, input int unsigned x, input int unsigned er, input int unsigned em);
    send(k, x);
    for (int t = 0; t < 20 && !ov[k]; t++) begin
      @(posedge clk); #1;
    end
    chk("lit_root", oroot[k], er);
`ifdef ANFSQRT_REM_EN
    chk("lit_rem", orem[k], em);
`else
    if (em > 2 * er) chk("lit_rem_range", em, 2 * er);
`endif
    wait_done(k);
  endtask

  task automatic rnd_run(input int k, input int cnt);
    int unsigned x;
    for (int j = 0; j < cnt; j++) begin
      if (j % 5 == 0) begin
        x = $urandom_range(255);
        x = x * x;
      end else begin
        x = $urandom_range(65535);
      end
      send(k, x);
      wait_done(k);
    end
  endtask

  initial begin
    int c0;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; id[k] = '0; ordy[k] = 1'b1;
    end
    #3;
    for (int k = 0; k < 3; k++) begin
      chk("reset_in_ready", ir[k], 1);
      chk("reset_out_valid", ov[k], 0);
      chk("reset_out_root", oroot[k], 0);
`ifdef ANFSQRT_REM_EN
      chk("reset_out_rem", orem[k], 0);
`endif
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed values on UNROLL=1.
    send_lit(0, 0, 0, 0);
    send_lit(0, 65535, 255, 510);
    send_lit(0, 16, 4, 0);
    send_lit(0, 15, 3, 6);

    // Hold the result for 5 cycles; in_valid during the hold must be ignored.
    ordy[0] = 1'b0;
    send(0, 200);
    for (int t = 0; t < 20 && !ov[0]; t++) begin
      @(posedge clk); #1;
    end
    for (int t = 0; t < 5; t++) begin
      iv[0] = 1'b1; id[0] = 16'd12345;
      @(posedge clk); #1;
      chk("hold_out_valid", ov[0], 1);
      chk("hold_root", oroot[0], 14);
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    chk("idle_in_ready", ir[0], 1);
    send(0, 144);
    chk("accept_after_hs", acc[0] - c0, 2);
    wait_done(0);

    // Reset during BUSY cycle 4.
    send(0, 50000);
    for (int t = 0; t < 3; t++) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", ov[0], 0);
    chk("midrst_in_ready", ir[0], 1);
    chk("midrst_out_root", oroot[0], 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(posedge clk); #1;
      if (ov[0]) chk("midrst_no_valid", ov[0], 0);
    end
    send_lit(0, 100, 10, 0);

    // Unrolled instances.
    send_lit(1, 1000, 31, 39);
    send_lit(2, 1000, 31, 39);
    send_lit(1, 65535, 255, 510);
    send_lit(2, 0, 0, 0);
    send_lit(2, 65535, 255, 510);

    // Random traffic, all three instances at once.
    fork
      rnd_run(0, 300);
      rnd_run(1, 500);
      rnd_run(2, 800);
    join

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
